// File: rtl/protocol_req_parser_if.sv
// rtl/protocol_req_parser_if.sv - byte-in / request-out bus of the request parser
// Purpose: bundles the UART byte strobe, the validated-request handshake and
//          the discard reporting of protocol_req_parser.
// Signals: rx_data/rx_valid          byte stream from the UART receiver
//          sensor_address/command    pending request payload
//          cmd_valid/cmd_ready       request handshake
//          frame_error/error_code    discard pulse and sticky cause
// Modports: slave = the parser, master = the byte source / request consumer.
interface protocol_req_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] sensor_address;
  logic [7:0] command;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       frame_error;
  logic [2:0] error_code;

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output sensor_address, command, cmd_valid, frame_error, error_code
  );

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  sensor_address, command, cmd_valid, frame_error, error_code
  );
endinterface

// File: rtl/protocol_req_parser.sv
// rtl/protocol_req_parser.sv - 4-byte request frame parser with valid/ready output
// Purpose: recognises FF <addr> <cmd> 7F frames in the UART byte stream, checks
//          address and command range, and holds one validated request until the
//          consumer accepts it. Discarded frames/bytes give a one-cycle
//          frame_error pulse and a sticky error_code
//          (1 footer, 2 address, 3 command, 4 inter-byte timeout, 5 overrun).
// Ports:   clk    - system clock, rising edge
//          reset  - asynchronous, active-low
//          bus    - protocol_req_parser_if.slave (byte in, request out, errors)
// Option:  PROTOCOL_REQ_TIMEOUT_EN - when defined, a partial frame idle for
//          TIMEOUT_CYCLES cycles is abandoned with code 4.
module protocol_req_parser #(
  parameter int unsigned SENSOR_COUNT   = 32,
  parameter logic [7:0]  MAX_COMMAND    = 8'h06,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  protocol_req_parser_if.slave bus
);

  localparam logic [7:0] HEADER_BYTE = 8'hFF;
  localparam logic [7:0] FOOTER_BYTE = 8'h7F;

  localparam logic [2:0] ERR_FOOTER  = 3'd1;
  localparam logic [2:0] ERR_ADDR    = 3'd2;
  localparam logic [2:0] ERR_CMD     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_FOOTER,
    S_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;             // address byte of the frame in flight
  logic [7:0] cmd_q, cmd_d;               // command byte of the frame in flight
  logic [7:0] sensor_address_q, sensor_address_d;
  logic [7:0] command_q, command_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       frame_error_q, frame_error_d;
  logic [2:0] error_code_q, error_code_d;
  logic       handshake;

  assign handshake = cmd_valid_q && bus.cmd_ready;

`ifdef PROTOCOL_REQ_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic [19:0] unused_tmo_last;
  assign unused_tmo_last = 20'(TIMEOUT_CYCLES - 1);
`endif

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    cmd_d            = cmd_q;
    sensor_address_d = sensor_address_q;
    command_d        = command_q;
    cmd_valid_d      = cmd_valid_q;
    frame_error_d    = 1'b0;
    error_code_d     = error_code_q;
`ifdef PROTOCOL_REQ_TIMEOUT_EN
    tmo_cnt_d        = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Non-header bytes between frames are line noise, not errors.
        if (bus.rx_valid && bus.rx_data == HEADER_BYTE) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          addr_d  = bus.rx_data;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.rx_valid) begin
          cmd_d   = bus.rx_data;
          state_d = S_FOOTER;
        end
      end
      S_FOOTER: begin
        if (bus.rx_valid) begin
          state_d = S_IDLE;
          if (bus.rx_data != FOOTER_BYTE) begin
            frame_error_d = 1'b1;
            error_code_d  = ERR_FOOTER;
          end else if (32'(addr_q) >= SENSOR_COUNT) begin
            frame_error_d = 1'b1;
            error_code_d  = ERR_ADDR;
          end else if (cmd_q > MAX_COMMAND) begin
            frame_error_d = 1'b1;
            error_code_d  = ERR_CMD;
          end else begin
            sensor_address_d = addr_q;
            command_d        = cmd_q;
            cmd_valid_d      = 1'b1;
            state_d          = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (handshake) begin
          // A byte in the accept cycle is treated as if already in IDLE so a
          // header can start the next frame with no dead cycle.
          cmd_valid_d = 1'b0;
          state_d     = (bus.rx_valid && bus.rx_data == HEADER_BYTE) ? S_ADDR : S_IDLE;
        end else if (bus.rx_valid) begin
          frame_error_d = 1'b1;
          error_code_d  = ERR_OVERRUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PROTOCOL_REQ_TIMEOUT_EN
    // Counter clears on every byte (default above); a byte in the expiry
    // cycle therefore beats the timeout.
    if ((state_q == S_ADDR || state_q == S_CMD || state_q == S_FOOTER) && !bus.rx_valid) begin
      if (tmo_cnt_q == TMO_LAST) begin
        frame_error_d = 1'b1;
        error_code_d  = ERR_TIMEOUT;
        state_d       = S_IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 20'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      cmd_q            <= '0;
      sensor_address_q <= '0;
      command_q        <= '0;
      cmd_valid_q      <= 1'b0;
      frame_error_q    <= 1'b0;
      error_code_q     <= '0;
`ifdef PROTOCOL_REQ_TIMEOUT_EN
      tmo_cnt_q        <= '0;
`endif
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      cmd_q            <= cmd_d;
      sensor_address_q <= sensor_address_d;
      command_q        <= command_d;
      cmd_valid_q      <= cmd_valid_d;
      frame_error_q    <= frame_error_d;
      error_code_q     <= error_code_d;
`ifdef PROTOCOL_REQ_TIMEOUT_EN
      tmo_cnt_q        <= tmo_cnt_d;
`endif
    end
  end

  assign bus.sensor_address = sensor_address_q;
  assign bus.command        = command_q;
  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.frame_error    = frame_error_q;
  assign bus.error_code     = error_code_q;

endmodule

// File: tb/tb_protocol_req_parser.sv
// tb/tb_protocol_req_parser.sv - scoreboard testbench for protocol_req_parser
module tb_protocol_req_parser;

  localparam int unsigned SENSOR_COUNT = 32;
  localparam logic [7:0]  MAX_COMMAND  = 8'h06;
  localparam int unsigned TMO          = 100;

  typedef struct {
    bit         is_err;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic [2:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  protocol_req_parser_if bus();

  protocol_req_parser #(
    .SENSOR_COUNT  (SENSOR_COUNT),
    .MAX_COMMAND   (MAX_COMMAND),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic exp_t model_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] f);
    exp_t e;
    e.is_err = 1'b0;
    e.addr   = a;
    e.cmd    = c;
    e.code   = 3'd0;
    if (f != 8'h7F) begin
      e.is_err = 1'b1; e.code = 3'd1;
    end else if (32'(a) >= SENSOR_COUNT) begin
      e.is_err = 1'b1; e.code = 3'd2;
    end else if (c > MAX_COMMAND) begin
      e.is_err = 1'b1; e.code = 3'd3;
    end
    return e;
  endfunction

  function automatic exp_t err_ev(input logic [2:0] code);
    exp_t e;
    e.is_err = 1'b1;
    e.addr   = 8'h00;
    e.cmd    = 8'h00;
    e.code   = code;
    return e;
  endfunction

  // Called at posedge+1; leaves at posedge+1 after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] f);
    send_byte(8'hFF);
    send_byte(a);
    send_byte(c);
    send_byte(f);
  endtask

  task automatic monitor_loop();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.frame_error) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL error_event: got code %0d, expected no event", bus.error_code);
          end else begin
            e = exp_q.pop_front();
            if (!e.is_err || bus.error_code !== e.code)
              $display("FAIL error_event: got code %0d, expected %s", bus.error_code,
                       e.is_err ? $sformatf("code %0d", e.code) : $sformatf("request %02h/%02h", e.addr, e.cmd));
            else n_pass++;
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL request_event: got %02h/%02h, expected no event", bus.sensor_address, bus.command);
          end else begin
            e = exp_q.pop_front();
            if (e.is_err || bus.sensor_address !== e.addr || bus.command !== e.cmd)
              $display("FAIL request_event: got %02h/%02h, expected %s", bus.sensor_address, bus.command,
                       e.is_err ? $sformatf("error code %0d", e.code) : $sformatf("request %02h/%02h", e.addr, e.cmd));
            else n_pass++;
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d outstanding events, expected 0", name, exp_q.size());
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cmd_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.cmd_valid, bus.sensor_address, bus.command, bus.frame_error, bus.error_code} !== 20'd0)
      $display("FAIL reset_outputs: got v=%b a=%02h c=%02h e=%b code=%0d, expected all 0",
               bus.cmd_valid, bus.sensor_address, bus.command, bus.frame_error, bus.error_code);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.cmd_valid, bus.frame_error} !== 2'b00)
      $display("FAIL reset_release: got v=%b e=%b, expected 0 0", bus.cmd_valid, bus.frame_error);
    else n_pass++;
  endtask

  task automatic test_single();
    bus.cmd_ready = 1'b1;
    exp_q.push_back(model_frame(8'h05, 8'h01, 8'h7F));
    send_frame(8'h05, 8'h01, 8'h7F);
    @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== 1'b1) $display("FAIL single_valid_n1: got %b, expected 1", bus.cmd_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== 1'b0) $display("FAIL single_valid_n2: got %b, expected 0", bus.cmd_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    drain("single");
  endtask

  task automatic test_leading_noise();
    bus.cmd_ready = 1'b1;
    exp_q.push_back(model_frame(8'h03, 8'h02, 8'h7F));
    send_byte(8'h12);
    send_byte(8'h34);
    send_frame(8'h03, 8'h02, 8'h7F);
    drain("leading");
  endtask

  task automatic test_frame_checks();
    logic [7:0] ta[8] = '{8'h05, 8'h40, 8'h05, 8'h20, 8'h1F, 8'hFF, 8'h40, 8'h1F};
    logic [7:0] tc[8] = '{8'h01, 8'h01, 8'h09, 8'h06, 8'h07, 8'h00, 8'h09, 8'h06};
    logic [7:0] tf[8] = '{8'h7E, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7E, 8'h7F};
    logic [2:0] last_code = 3'd0;
    exp_t e;
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = model_frame(ta[i], tc[i], tf[i]);
      if (e.is_err) last_code = e.code;
      exp_q.push_back(e);
      send_frame(ta[i], tc[i], tf[i]);
    end
    drain("frame_checks");
    n_checks++;
    if (bus.error_code !== last_code) $display("FAIL sticky_code: got %0d, expected %0d", bus.error_code, last_code);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.cmd_ready = 1'b1;
    exp_q.push_back(model_frame(8'h05, 8'h01, 8'h7F));
    exp_q.push_back(model_frame(8'h06, 8'h02, 8'h7F));
    exp_q.push_back(model_frame(8'h07, 8'h00, 8'h7F));
    exp_q.push_back(model_frame(8'h08, 8'h03, 8'h7F));
    send_frame(8'h05, 8'h01, 8'h7F);
    send_frame(8'h06, 8'h02, 8'h7F);
    send_frame(8'h07, 8'h00, 8'h7F);
    send_byte(8'h33);
    send_frame(8'h08, 8'h03, 8'h7F);
    drain("back_to_back");
  endtask

  task automatic test_overrun();
    bus.cmd_ready = 1'b0;
    exp_q.push_back(err_ev(3'd5));
    exp_q.push_back(model_frame(8'h02, 8'h03, 8'h7F));
    send_frame(8'h02, 8'h03, 8'h7F);
    @(posedge clk);
    #1;
    send_byte(8'h55);
    @(negedge clk);
    n_checks++;
    if ({bus.frame_error, bus.cmd_valid, bus.sensor_address, bus.command} !== {1'b1, 1'b1, 8'h02, 8'h03})
      $display("FAIL overrun_stable: got e=%b v=%b a=%02h c=%02h, expected e=1 v=1 a=02 c=03",
               bus.frame_error, bus.cmd_valid, bus.sensor_address, bus.command);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.frame_error, bus.cmd_valid} !== 2'b01)
      $display("FAIL overrun_single_pulse: got e=%b v=%b, expected e=0 v=1", bus.frame_error, bus.cmd_valid);
    else n_pass++;
    @(posedge clk);
    #1 bus.cmd_ready = 1'b1;
    @(posedge clk);
    #1 bus.cmd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.cmd_valid, bus.error_code} !== {1'b0, 3'd5})
      $display("FAIL overrun_release: got v=%b code=%0d, expected v=0 code=5", bus.cmd_valid, bus.error_code);
    else n_pass++;
    @(posedge clk);
    #1;
    drain("overrun");
  endtask

`ifdef PROTOCOL_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bus.cmd_ready = 1'b1;
    exp_q.push_back(err_ev(3'd4));
    send_byte(8'hFF);
    send_byte(8'h05);
    // TMO idle cycles after the last byte, pulse visible in the cycle after.
    while (bus.frame_error !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != TMO + 1) $display("FAIL timeout_latency: got %0d, expected %0d", n, TMO + 1);
    else n_pass++;
    @(posedge clk);
    #1;
    exp_q.push_back(model_frame(8'h05, 8'h01, 8'h7F));
    send_frame(8'h05, 8'h01, 8'h7F);
    drain("timeout_recover");
    exp_q.push_back(model_frame(8'h09, 8'h04, 8'h7F));
    send_byte(8'hFF);
    send_byte(8'h09);
    repeat (TMO - 1) begin
      @(posedge clk);
      #1;
    end
    send_byte(8'h04);
    send_byte(8'h7F);
    drain("timeout_expiry_byte");
  endtask
`else
  task automatic test_timeout();
    bus.cmd_ready = 1'b1;
    exp_q.push_back(model_frame(8'h05, 8'h01, 8'h7F));
    send_byte(8'hFF);
    send_byte(8'h05);
    repeat (3 * TMO) begin
      @(posedge clk);
      #1;
    end
    send_byte(8'h01);
    send_byte(8'h7F);
    drain("no_timeout");
  endtask
`endif

  task automatic test_reset_in_hold();
    bus.cmd_ready = 1'b0;
    exp_q.push_back(err_ev(3'd5));
    send_frame(8'h04, 8'h02, 8'h7F);
    send_byte(8'h11);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.cmd_valid, bus.sensor_address, bus.command, bus.frame_error, bus.error_code} !== 20'd0)
      $display("FAIL reset_in_hold: got v=%b a=%02h c=%02h e=%b code=%0d, expected all 0",
               bus.cmd_valid, bus.sensor_address, bus.command, bus.frame_error, bus.error_code);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b1;
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.cmd_valid !== 1'b0) $display("FAIL reset_lost_request: got %b, expected 0", bus.cmd_valid);
    else n_pass++;
    exp_q.push_back(model_frame(8'h01, 8'h01, 8'h7F));
    send_frame(8'h01, 8'h01, 8'h7F);
    drain("reset_recover");
  endtask

  initial begin
    fork
      monitor_loop();
      begin
        test_reset();
        test_single();
        test_leading_noise();
        test_frame_checks();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_in_hold();
        done = 1'b1;
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/protocol_req_parser.md
# protocol_req_parser

Upstream neighbour of the response framer: consumes the byte stream from the UART receiver, recognises 4-byte request frames (header, sensor address, command, footer) and presents one validated request at a time to the sensor-control logic over a valid/ready handshake. Malformed, out-of-range, stalled or overrunning frames are discarded and reported through a one-cycle error pulse with a sticky error code.

## Interface
- `SENSOR_COUNT`, 32: number of addressable sensors; valid addresses are 0 to SENSOR_COUNT-1.
- `MAX_COMMAND`, 8'h06: highest legal command code; legal codes are 0x00 to MAX_COMMAND.
- `TIMEOUT_CYCLES`, 50000: maximum idle cycles between bytes inside a frame; 1 to 2^20.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `sensor_address`  out  8  address of the pending request.
- `command`  out  8  command code of the pending request.
- `cmd_valid`  out  1  request pending; held until accepted.
- `cmd_ready`  in  1  consumer accepts the request when high with `cmd_valid`.
- `frame_error`  out  1  one-cycle pulse per discarded frame or byte.
- `error_code`  out  3  cause of the most recent error; holds until the next error.

## Operation
- Frame: 0xFF header, address byte, command byte, 0x7F footer.
- States: IDLE, ADDR, CMD, FOOTER, HOLD.
- IDLE: byte 0xFF goes to ADDR. Any other byte is dropped silently with no error.
- ADDR: latch the byte as the address and go to CMD. A value of 0xFF is latched as an address.
- CMD: latch the byte as the command and go to FOOTER.
- FOOTER: check the frame in this priority order:
  - footer not 0x7F: code 3'd1;
  - address ≥ SENSOR_COUNT: code 3'd2;
  - command > MAX_COMMAND: code 3'd3.
- Any failed check pulses `frame_error`, loads `error_code` and returns to IDLE. A passing frame loads `sensor_address` and `command` and goes to HOLD.
- HOLD: `cmd_valid`=1. Outputs stay stable until `cmd_valid && cmd_ready`, then return to IDLE.
- `rx_valid` in HOLD without a handshake: the byte is dropped, `frame_error` pulses, code 3'd5 (overrun), and the block stays in HOLD.
- `rx_valid` in the handshake cycle: the byte is processed as in IDLE. A 0xFF byte therefore goes directly to ADDR.
- Reset values: `cmd_valid`=0, `sensor_address`=0, `command`=0, `frame_error`=0, `error_code`=0, state IDLE, timeout counter 0.
- Reset asserted mid-frame or in HOLD: the partial or pending request is lost and all outputs take their reset values immediately.

## Timing
- Footer strobe in cycle N: `cmd_valid` or `frame_error` is high in cycle N+1.
- With `cmd_ready` tied high, `cmd_valid` is high for exactly one cycle.
- `cmd_valid` falls in the cycle after the handshake. Back-to-back frames are accepted with no dead cycle.
- `frame_error` is never high for two consecutive cycles from a single event. Consecutive events produce consecutive pulses.
- `error_code` updates in the same cycle as its `frame_error` pulse.
- No throughput limit beyond one byte per cycle.

## Configuration
- `PROTOCOL_REQ_TIMEOUT_EN` defined:
  - A 20-bit counter runs in ADDR, CMD and FOOTER and clears on every `rx_valid`.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte, the next cycle pulses `frame_error` with code 3'd4 and returns to IDLE.
  - A byte arriving in the expiry cycle wins and is processed normally.
  - The counter holds 0 in IDLE and HOLD.
- Not defined: no counter is built, partial frames wait indefinitely, and code 3'd4 never occurs.

## Test plan
- Send FF 05 01 7F with `cmd_ready`=1 → one-cycle `cmd_valid` with `sensor_address`=0x05, `command`=0x01; no `frame_error`.
- Send 12 34 FF 03 02 7F → leading bytes ignored; request with 0x03/0x02 issued.
- Send FF 05 01 7E, then FF 40 01 7F, then FF 05 09 7F → three `frame_error` pulses with codes 1, 2, 3; `cmd_valid` never rises.
- Hold `cmd_ready`=0 after FF 02 03 7F and send byte 0x55 → outputs stay stable, `frame_error` pulses with code 5. Then raise `cmd_ready` for one cycle → `cmd_valid` drops next cycle.
- With the macro defined and TIMEOUT_CYCLES=100: send FF 05 and wait 100 cycles → code 4 and state IDLE. Then send FF 05 01 7F → valid request.
- Assert `reset` low in HOLD → `cmd_valid`, `sensor_address`, `command` and `error_code` are 0 before the next clock edge.
